// File: rtl/seq_resp_pkg.sv
// Shared types and constants for the sequencer ack responder.
package seq_resp_pkg;

  localparam int unsigned C_ACK_CNT_W = 16;

  typedef enum logic [1:0] {
    CmdNop   = 2'd0,
    CmdDelay = 2'd1,
    CmdWrite = 2'd2,
    CmdRead  = 2'd3
  } t_resp_cmd;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } t_resp_state;

endpackage

// File: rtl/seq_resp_fifo.sv
// Synchronous FIFO with registered full/empty flags; Depth must be a power of two.
module seq_resp_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [Width-1:0] mem_q [Depth];
  logic             push_en;
  logic             pop_en;

  // Flags gate the requests, so a pop while full never frees a slot in the same cycle.
  assign push_en = push_i & ~full_q;
  assign pop_en  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    empty_d  = empty_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    if (push_en && !pop_en) begin
      empty_d = 1'b0;
      full_d  = (wr_ptr_d == rd_ptr_q);
    end else if (pop_en && !push_en) begin
      full_d  = 1'b0;
      empty_d = (rd_ptr_d == wr_ptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/seq_ack_responder.sv
// Far-end responder for the sequencer: queues commands and returns in-order
// ack pulses after a programmable latency.
module seq_ack_responder
  import seq_resp_pkg::*;
#(
  parameter int unsigned G_DATA_WIDTH  = 8,
  parameter int unsigned G_FIFO_DEPTH  = 4,
  parameter int unsigned G_ACK_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_cmd,
  input  logic [G_DATA_WIDTH-1:0] req_data,
  output logic                    ack,
  output logic [G_DATA_WIDTH-1:0] ack_data,
  output logic                    busy,
  output logic [C_ACK_CNT_W-1:0]  ack_cnt
);

  localparam int unsigned CntW   = G_DATA_WIDTH + 1;
  localparam int unsigned EntryW = G_DATA_WIDTH + 2;

  t_resp_state             state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  t_resp_cmd               cmd_q, cmd_d;
  logic [G_DATA_WIDTH-1:0] data_q, data_d;
  logic [G_DATA_WIDTH-1:0] reg_q, reg_d;
  logic [C_ACK_CNT_W-1:0]  ack_cnt_q, ack_cnt_d;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [EntryW-1:0]       fifo_rdata;
  t_resp_cmd               head_cmd;
  logic [G_DATA_WIDTH-1:0] head_data;
  logic [CntW-1:0]         cnt_load;

  assign fifo_push = req_valid & ~fifo_full;

  seq_resp_fifo #(
    .Width (EntryW),
    .Depth (G_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i ({req_cmd, req_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_cmd  = t_resp_cmd'(fifo_rdata[EntryW-1 -: 2]);
  assign head_data = fifo_rdata[G_DATA_WIDTH-1:0];
  // One extra bit keeps latency + delay operand from overflowing.
  assign cnt_load  = CntW'(G_ACK_LATENCY) +
                     ((head_cmd == CmdDelay) ? {1'b0, head_data} : '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    reg_d     = reg_q;
    ack_cnt_d = ack_cnt_q;
    fifo_pop  = 1'b0;
    ack       = 1'b0;
    ack_data  = '0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = head_cmd;
          data_d   = head_data;
          cnt_d    = cnt_load;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StAck;
          if (cmd_q == CmdWrite) reg_d = data_q;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StAck: begin
        ack       = 1'b1;
        ack_data  = (cmd_q == CmdRead) ? reg_q : data_q;
        ack_cnt_d = ack_cnt_q + C_ACK_CNT_W'(1);
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cmd_q     <= CmdNop;
      data_q    <= '0;
      reg_q     <= '0;
      ack_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      reg_q     <= reg_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

  assign req_ready = ~fifo_full;
  assign busy      = ~fifo_empty | (state_q != StIdle);
  assign ack_cnt   = ack_cnt_q;

endmodule

// File: tb/tb_seq_ack_responder.sv
// Randomised self-checking bench for seq_ack_responder against a timing/data reference model.
module tb_seq_ack_responder;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_cmd = 2'd0;
  logic [DW-1:0] req_data = '0;
  logic          ack;
  logic [DW-1:0] ack_data;
  logic          busy;
  logic [15:0]   ack_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: expected ack edge/data per accepted command, and each one's pop edge.
  int            exp_cyc[$];
  logic [DW-1:0] exp_dat[$];
  int            pop_q[$];
  int            obs_cyc[$];
  logic [DW-1:0] obs_dat[$];
  int            prev_ack = -100;
  logic [DW-1:0] model_reg = '0;
  int            ack_total = 0;

  seq_ack_responder #(
    .G_DATA_WIDTH  (DW),
    .G_FIFO_DEPTH  (DEPTH),
    .G_ACK_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_data  (req_data),
    .ack       (ack),
    .ack_data  (ack_data),
    .busy      (busy),
    .ack_cnt   (ack_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ack === 1'b1) begin
      obs_cyc.push_back(cyc);
      obs_dat.push_back(ack_data);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
    $fatal(1);
  end

  function automatic bit model_ready();
    int occ;
    occ = 0;
    foreach (pop_q[i]) if (pop_q[i] > cyc) occ++;
    return occ < DEPTH;
  endfunction

  task automatic model_accept(input logic [1:0] cmd, input logic [DW-1:0] data, input int a);
    int lat;
    int p;
    lat = LAT + ((cmd == 2'd1) ? int'(data) : 0);
    p   = (a + 1 > prev_ack + 2) ? a + 1 : prev_ack + 2;
    pop_q.push_back(p);
    prev_ack = p + lat + 1;
    exp_cyc.push_back(prev_ack);
    case (cmd)
      2'd2: begin model_reg = data; exp_dat.push_back(data); end
      2'd3: exp_dat.push_back(model_reg);
      default: exp_dat.push_back(data);
    endcase
    ack_total++;
  endtask

  task automatic model_clear();
    exp_cyc.delete();
    exp_dat.delete();
    pop_q.delete();
    obs_cyc.delete();
    obs_dat.delete();
  endtask

  task automatic do_reset();
    obs_cyc.delete();
    obs_dat.delete();
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    prev_ack  = -100;
    model_reg = '0;
    ack_total = 0;
  endtask

  // Leaves req_valid high so consecutive calls are back-to-back.
  task automatic send(input logic [1:0] cmd, input logic [DW-1:0] data, output int acc);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    acc   = -1;
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_data  = data;
    while (!done) begin
      total++;
      if (req_ready !== model_ready()) begin
        bad++;
        $display("FAIL send_ready cyc=%0d got=%b exp=%b", cyc, req_ready, model_ready());
      end
      if (req_ready === 1'b1) begin
        acc  = cyc + 1;
        done = 1'b1;
        model_accept(cmd, data, acc);
      end
      @(negedge clk);
      guard++;
      if (!done && guard > 600) begin
        total++;
        bad++;
        $display("FAIL send_timeout cyc=%0d got=no_accept exp=accept", cyc);
        done = 1'b1;
      end
    end
  endtask

  task automatic drain(input string tag);
    int stop;
    int n;
    stop = prev_ack + 3;
    while (cyc < stop) begin
      total++;
      if (req_ready !== model_ready()) begin
        bad++;
        $display("FAIL %s_ready cyc=%0d got=%b exp=%b", tag, cyc, req_ready, model_ready());
      end
      @(negedge clk);
    end
    total++;
    if (obs_cyc.size() != exp_cyc.size()) begin
      bad++;
      $display("FAIL %s_ack_count got=%0d exp=%0d", tag, obs_cyc.size(), exp_cyc.size());
    end
    n = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_cyc[i] != exp_cyc[i] || obs_dat[i] !== exp_dat[i]) begin
        bad++;
        $display("FAIL %s_ack[%0d] got cyc=%0d data=%h exp cyc=%0d data=%h", tag, i,
                 obs_cyc[i], obs_dat[i], exp_cyc[i], exp_dat[i]);
      end
    end
    total++;
    if (ack_cnt !== 16'(ack_total)) begin
      bad++;
      $display("FAIL %s_ack_cnt got=%0d exp=%0d", tag, ack_cnt, ack_total);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy_idle got=%b exp=0", tag, busy);
    end
  endtask

  task automatic test_reset();
    int a;
    do_reset();
    total += 5;
    if (ack !== 1'b0)       begin bad++; $display("FAIL reset_ack got=%b exp=0", ack); end
    if (ack_cnt !== 16'd0)  begin bad++; $display("FAIL reset_ack_cnt got=%0d exp=0", ack_cnt); end
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (ack_data !== '0)    begin bad++; $display("FAIL reset_ack_data got=%h exp=0", ack_data); end
    send(2'd3, 8'hFF, a);
    req_valid = 1'b0;
    drain("reset_read");
    total++;
    if (obs_dat.size() != 1 || obs_dat[0] !== 8'h00) begin
      bad++;
      $display("FAIL reset_read_data got_n=%0d exp=00", obs_dat.size());
    end
  endtask

  task automatic test_nop();
    int a;
    do_reset();
    send(2'd0, 8'h3C, a);
    req_valid = 1'b0;
    drain("nop");
    total++;
    if (obs_cyc.size() != 1 || obs_cyc[0] != a + 5 || obs_dat[0] !== 8'h3C) begin
      bad++;
      $display("FAIL nop_latency got_n=%0d exp cyc=%0d data=3c", obs_cyc.size(), a + 5);
    end
  endtask

  task automatic test_write_read();
    int a;
    do_reset();
    send(2'd2, 8'hA5, a);
    send(2'd3, 8'h00, a);
    req_valid = 1'b0;
    drain("wr_rd");
    total++;
    if (obs_dat.size() != 2 || obs_dat[1] !== 8'hA5 || ack_cnt !== 16'd2) begin
      bad++;
      $display("FAIL wr_rd_data got_n=%0d ack_cnt=%0d exp data=a5 ack_cnt=2",
               obs_dat.size(), ack_cnt);
    end
  endtask

  task automatic test_delay();
    int a;
    do_reset();
    send(2'd1, 8'd10, a);
    req_valid = 1'b0;
    drain("delay");
    total++;
    if (obs_cyc.size() != 1 || obs_cyc[0] != a + 15) begin
      bad++;
      $display("FAIL delay_latency got_n=%0d exp cyc=%0d", obs_cyc.size(), a + 15);
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    int a;
    do_reset();
    send(2'd1, 8'd20, a0);
    for (int i = 1; i <= 4; i++) send(2'd0, 8'(i), a);
    req_valid = 1'b0;
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_full got=%b exp=0", req_ready);
    end
    // First queued NOP pops two edges after the DELAY ack.
    while (cyc < a0 + LAT + 20 + 3) @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_still_full got=%b exp=0", req_ready);
    end
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_reopen got=%b exp=1", req_ready);
    end
    drain("bp");
    for (int i = 0; i < 5 && i < obs_dat.size(); i++) begin
      total++;
      if (obs_dat[i] !== ((i == 0) ? 8'd20 : 8'(i)) ||
          (i > 0 && obs_cyc[i] - obs_cyc[i-1] != LAT + 3)) begin
        bad++;
        $display("FAIL bp_order[%0d] got data=%0d cyc=%0d exp data=%0d", i, obs_dat[i],
                 obs_cyc[i], (i == 0) ? 20 : i);
      end
    end
  endtask

  task automatic test_reset_mid();
    int a;
    do_reset();
    send(2'd1, 8'd40, a);
    send(2'd0, 8'h11, a);
    send(2'd0, 8'h22, a);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    do_reset();
    repeat (70) @(negedge clk);
    total++;
    if (obs_cyc.size() != 0 || ack_cnt !== 16'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got acks=%0d ack_cnt=%0d busy=%b exp 0 0 0",
               obs_cyc.size(), ack_cnt, busy);
    end
    send(2'd0, 8'h5A, a);
    req_valid = 1'b0;
    drain("mid_reset_nop");
    total++;
    if (obs_cyc.size() != 1 || obs_cyc[0] != a + 5) begin
      bad++;
      $display("FAIL mid_reset_latency got_n=%0d exp cyc=%0d", obs_cyc.size(), a + 5);
    end
  endtask

  task automatic test_random();
    int a;
    logic [1:0]    cmd;
    logic [DW-1:0] data;
    for (int r = 0; r < 3; r++) begin
      model_clear();
      for (int k = 0; k < 16; k++) begin
        cmd  = 2'($urandom_range(0, 3));
        data = (cmd == 2'd1) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
        send(cmd, data, a);
        if ($urandom_range(0, 1) == 1) begin
          req_valid = 1'b0;
          repeat ($urandom_range(1, 4)) @(negedge clk);
        end
      end
      req_valid = 1'b0;
      drain("random");
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_nop();
    test_write_read();
    test_delay();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
